// File: rtl/complex_operand_dispatch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | complex_operand_dispatch: pair FIFO that fans each head pair out to four   |
// | independently handshaken operand channels.            Revision: 1.0        |
// +-----------------------------------------------------------------------------+
module complex_operand_dispatch #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              in_a_real,
  input  logic [63:0]              in_a_imag,
  input  logic [63:0]              in_b_real,
  input  logic [63:0]              in_b_imag,
  input  logic                     in_stb,
  output logic                     in_ack,
  output logic [63:0]              output_a_real,
  output logic [63:0]              output_a_imag,
  output logic [63:0]              output_b_real,
  output logic [63:0]              output_b_imag,
  output logic                     output_a_real_stb,
  output logic                     output_a_imag_stb,
  output logic                     output_b_real_stb,
  output logic                     output_b_imag_stb,
  input  logic                     output_a_real_ack,
  input  logic                     output_a_imag_ack,
  input  logic                     output_b_real_ack,
  input  logic                     output_b_imag_ack,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [255:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    done;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [3:0]    stb;
  logic [3:0]    ack;
  logic [3:0]    xfer;
  logic [255:0]  head;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ack = !full;
  assign push   = in_stb && !full;

  // Channel order throughout: bit 0 a_real, 1 a_imag, 2 b_real, 3 b_imag.
  assign ack  = {output_b_imag_ack, output_b_real_ack, output_a_imag_ack, output_a_real_ack};
  assign stb  = empty ? 4'b0000 : ~done;
  assign xfer = stb & ack;
  assign pop  = !empty && (&(done | xfer));

  assign output_a_real_stb = stb[0];
  assign output_a_imag_stb = stb[1];
  assign output_b_real_stb = stb[2];
  assign output_b_imag_stb = stb[3];

  assign head          = mem[rd_ptr[AW-1:0]];
  assign output_a_real = head[63:0];
  assign output_a_imag = head[127:64];
  assign output_b_real = head[191:128];
  assign output_b_imag = head[255:192];

  assign level = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_b_imag, in_b_real, in_a_imag, in_a_real};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      done         <= 4'b0000;
      issued_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_ONE;
        done         <= 4'b0000;
        issued_count <= issued_count + CNT_ONE;
      end else begin
        done <= done | xfer;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_complex_operand_dispatch.sv
`default_nettype none
// tb_complex_operand_dispatch: random stimulus against a queue-based model of
// the pair buffer and its four operand channels.
module tb_complex_operand_dispatch;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] in_a_real = '0, in_a_imag = '0, in_b_real = '0, in_b_imag = '0;
  logic        in_stb = 1'b0;
  logic        in_ack;
  logic [63:0] output_a_real, output_a_imag, output_b_real, output_b_imag;
  logic        output_a_real_stb, output_a_imag_stb, output_b_real_stb, output_b_imag_stb;
  logic        output_a_real_ack = 1'b0, output_a_imag_ack = 1'b0;
  logic        output_b_real_ack = 1'b0, output_b_imag_ack = 1'b0;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] issued_count;

  always #5 clk = ~clk;

  complex_operand_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_a_real(in_a_real), .in_a_imag(in_a_imag),
    .in_b_real(in_b_real), .in_b_imag(in_b_imag),
    .in_stb(in_stb), .in_ack(in_ack),
    .output_a_real(output_a_real), .output_a_imag(output_a_imag),
    .output_b_real(output_b_real), .output_b_imag(output_b_imag),
    .output_a_real_stb(output_a_real_stb), .output_a_imag_stb(output_a_imag_stb),
    .output_b_real_stb(output_b_real_stb), .output_b_imag_stb(output_b_imag_stb),
    .output_a_real_ack(output_a_real_ack), .output_a_imag_ack(output_a_imag_ack),
    .output_b_real_ack(output_b_real_ack), .output_b_imag_ack(output_b_imag_ack),
    .level(level), .issued_count(issued_count)
  );

  logic [3:0]  stb_v;
  logic [63:0] dout [4];
  assign stb_v   = {output_b_imag_stb, output_b_real_stb, output_a_imag_stb, output_a_real_stb};
  assign dout[0] = output_a_real;
  assign dout[1] = output_a_imag;
  assign dout[2] = output_b_real;
  assign dout[3] = output_b_imag;

  // Reference model: pending pairs in arrival order, which channels have
  // already taken the head pair, and the retirement count.
  logic [255:0]     q [$];
  logic [3:0]       taken = 4'b0000;
  logic [CNT_W-1:0] cnt = '0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_pair(input logic [63:0] ar, input logic [63:0] ai,
                          input logic [63:0] br, input logic [63:0] bi);
    in_a_real = ar; in_a_imag = ai; in_b_real = br; in_b_imag = bi;
  endtask

  task automatic set_acks(input logic [3:0] a);
    output_a_real_ack = a[0]; output_a_imag_ack = a[1];
    output_b_real_ack = a[2]; output_b_imag_ack = a[3];
  endtask

  task automatic rand_pair();
    set_pair({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Called just after a falling edge with inputs already driven: compare,
  // then advance the model across the next rising edge.
  task automatic cycle();
    logic [3:0]   acks;
    logic [255:0] pair;
    logic [255:0] hd;
    bit           do_push;
    acks = {output_b_imag_ack, output_b_real_ack, output_a_imag_ack, output_a_real_ack};
    pair = {in_b_imag, in_b_real, in_a_imag, in_a_real};
    check("in_ack", 64'(in_ack), 64'(q.size() < DEPTH));
    check("level", 64'(level), 64'(q.size()));
    check("issued_count", 64'(issued_count), 64'(cnt));
    for (int i = 0; i < 4; i++)
      check($sformatf("stb%0d", i), 64'(stb_v[i]), 64'(q.size() > 0 && !taken[i]));
    if (q.size() > 0) begin
      hd = q[0];
      for (int i = 0; i < 4; i++)
        check($sformatf("data%0d", i), dout[i], hd[64*i +: 64]);
    end
    do_push = in_stb && (q.size() < DEPTH);
    @(posedge clk);
    if (q.size() > 0) begin
      taken = taken | acks;
      if (taken == 4'b1111) begin
        void'(q.pop_front());
        taken = 4'b0000;
        cnt   = cnt + 1'b1;
      end
    end
    if (do_push) q.push_back(pair);
    @(negedge clk);
  endtask

  // Pushes n random pairs (each held until accepted) with random in_stb and
  // per-channel acks; acks are forced low for the first `hold` cycles.
  task automatic stream(input int n, input int stb_pct, input int ack_pct, input int hold);
    int pushed = 0;
    int cyc = 0;
    bit have = 0;
    bit accepted;
    logic [3:0] a;
    while ((pushed < n || q.size() > 0) && cyc < 500) begin
      if (pushed < n && !have) begin
        rand_pair();
        have = 1;
      end
      in_stb = have && ($urandom_range(99) < stb_pct);
      for (int i = 0; i < 4; i++)
        a[i] = (cyc >= hold) && ($urandom_range(99) < ack_pct);
      set_acks(a);
      accepted = in_stb && (q.size() < DEPTH);
      cycle();
      if (accepted) begin
        pushed++;
        have = 0;
      end
      cyc++;
    end
    check("stream_completed", 64'(pushed == n && q.size() == 0), 64'd1);
    in_stb = 1'b0;
    set_acks(4'b0000);
  endtask

  initial begin
    logic [3:0] sched [5];
    sched = '{4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0110};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ack", 64'(in_ack), 64'd1);
    check("rst_stb", 64'(stb_v), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_data", dout[0] | dout[1] | dout[2] | dout[3], 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single pair, all acks held high
    set_pair(64'h3FF0000000000000, 64'h4000000000000000,
             64'h4008000000000000, 64'hC010000000000000);
    set_acks(4'b1111);
    in_stb = 1'b1;
    cycle();
    in_stb = 1'b0;
    repeat (2) cycle();
    check("single_count", 64'(issued_count), 64'd1);

    // Staggered per-channel acks
    set_acks(4'b0000);
    rand_pair();
    in_stb = 1'b1;
    cycle();
    in_stb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_acks(sched[k]);
      cycle();
    end
    set_acks(4'b0000);
    cycle();
    check("stagger_count", 64'(issued_count), 64'd2);

    // Fill past capacity with acks stalled, then release
    stream(6, 100, 100, 8);

    // Random streaming across several pointer wraps
    stream(20, 70, 60, 0);

    // Reset in the middle of a partially acknowledged head
    for (int k = 0; k < 3; k++) begin
      rand_pair();
      in_stb = 1'b1;
      cycle();
    end
    in_stb = 1'b0;
    set_acks(4'b0001);
    cycle();
    set_acks(4'b0000);
    #2 rst = 1'b1;
    #1;
    check("midrst_stb", 64'(stb_v), 64'd0);
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_in_ack", 64'(in_ack), 64'd1);
    check("midrst_count", 64'(issued_count), 64'd0);
    q.delete();
    taken = 4'b0000;
    cnt   = '0;
    @(negedge clk);
    rst = 1'b0;
    rand_pair();
    in_stb = 1'b1;
    cycle();
    in_stb = 1'b0;
    cycle();
    set_acks(4'b1111);
    cycle();
    set_acks(4'b0000);
    cycle();

    // Counter wrap with full-rate streaming
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    taken = 4'b0000;
    cnt   = '0;
    stream(17, 100, 100, 0);
    check("wrap_count", 64'(issued_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
